stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Sequencing controller for the 1 MHz stopwatch counter datapath (HH:MM:SS, 00:00:00..99:59:59).
//  - Debounces the start_stop, Clear and lap buttons.
//  - Runs the IDLE/RUN/PAUSE state machine.
//  - Generates the 1 Hz count-enable tick, the clear pulse and the display lap-hold for the counter.
//  - Sits between the board buttons and the counter/BCD block. The counter only obeys sec_tick and clr_pulse.
// PARAMETERS
//  TICK_DIV  1000000  Clk cycles per counted second (prescaler modulus, >=2).
//  DEB_CYC   10000    Cycles an input must be stable before its new level is accepted (>=1).
// PORTS
//  Clk         in   1  System clock, 1 MHz nominal; single clock domain.
//  rst_n       in   1  Asynchronous active-low reset.
//  start_stop  in   1  Raw start/stop button, active high, asynchronous.
//  Clear       in   1  Raw clear button, active high, asynchronous.
//  lap         in   1  Raw lap button, active high, asynchronous.
//  sec_tick    out  1  One-cycle pulse: counter adds one second.
//  clr_pulse   out  1  One-cycle pulse: counter zeroes HH:MM:SS.
//  run_en      out  1  High while state==RUN.
//  lap_hold    out  1  High: display keeps its captured value while the counter keeps running.
//  state       out  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSE.
// BEHAVIOUR
//  - Reset: all outputs 0, state=IDLE, prescaler=0, debouncers at accepted level 0.
//  - Input path: each button goes through a 2-FF synchroniser, then a debouncer.
//    - Any change of the synchronised level restarts the stable-count.
//    - After DEB_CYC consecutive stable cycles, the new level is accepted.
//    - A 0->1 accepted transition gives a 1-cycle *_press pulse. No pulse on release.
//    - Latency: the press pulse is high exactly DEB_CYC+3 cycles after a clean pin rise.
//    - A glitch shorter than DEB_CYC cycles produces nothing.
//  - FSM, evaluated on press pulses:
//    - IDLE -ss-> RUN; RUN -ss-> PAUSE; PAUSE -ss-> RUN.
//    - clr_press from any state -> IDLE, with clr_pulse=1 in the same cycle as the transition.
//    - clr_press beats ss_press in the same cycle: end in IDLE, no RUN.
//    - While the Clear accepted level is high, ss_press is ignored and the FSM stays IDLE.
//  - Prescaler, 0..TICK_DIV-1:
//    - Increments only in RUN.
//    - sec_tick=1 in the cycle the count is TICK_DIV-1; it then wraps to 0.
//    - Holds its value in PAUSE, so resume keeps the fractional second.
//    - Forced to 0 in IDLE. The first tick after IDLE->RUN comes exactly TICK_DIV cycles after entering RUN.
//    - No sec_tick is ever issued outside RUN, including the cycle of a RUN->PAUSE or RUN->IDLE transition.
//  - Outputs are registered: run_en and state update the cycle after the press pulse. clr_pulse and sec_tick are registered 1-cycle pulses.
//  - rst_n asserted mid-operation: immediate return to reset values. A button held through reset must be released and re-pressed to act.
// CONFIGURATION
//  LAP_EN defined:
//    - In RUN, lap_press toggles lap_hold.
//    - In PAUSE, lap_press clears lap_hold.
//    - In IDLE, and on clr_pulse, lap_hold is forced to 0.
//  LAP_EN undefined:
//    - The lap port stays present but is ignored; no debouncer is instantiated for it.
//    - lap_hold is tied to 0.
// STRUCTURE
//  Package stopwatch_pkg:
//    - State encoding constants ST_IDLE=2'b00, ST_RUN=2'b01, ST_PAUSE=2'b10.
//    - Default TICK_DIV/DEB_CYC values, shared with the counter block.
//  Sub-module btn_debounce (params DEB_CYC):
//    - Contains the synchroniser, stable-counter and accepted level.
//    - Outputs: level, press.
//    - Instantiated once per button (three instances with LAP_EN, two without).
//  Top holds the FSM, prescaler and lap logic. Counter widths are sized with $clog2 of the parameters.
// TESTING  (bench overrides TICK_DIV=10, DEB_CYC=4)
//  1. Reset, then start_stop high for 20 cycles -> press at +7 cycles; state=01; first sec_tick exactly 10 cycles after state=01; then one tick every 10.
//  2. start_stop pulse 3 cycles wide (glitch) -> no press, state stays 00, no sec_tick.
//  3. RUN for 25 cycles, press ss -> PAUSE with prescaler=5; press ss again -> next sec_tick exactly 5 cycles after state returns to 01.
//  4. In RUN, Clear and start_stop rising on the same cycle -> one clr_pulse, state=00, prescaler 0, no tick afterwards.
//  5. Hold Clear high and press start_stop -> state stays 00. Release Clear, press start_stop -> RUN.
//  6. LAP_EN: in RUN press lap -> lap_hold=1, sec_tick continues; press lap again -> 0; lap in RUN then Clear -> lap_hold=0 with clr_pulse. Without LAP_EN: lap toggling leaves lap_hold=0.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// ----------------------------------------------------------------------------
// stopwatch_pkg : state encoding and default timing shared with the counter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package stopwatch_pkg;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_RUN   = 2'b01;
   localparam logic [1:0] ST_PAUSE = 2'b10;

   localparam int unsigned DEF_TICK_DIV = 1000000;
   localparam int unsigned DEF_DEB_CYC  = 10000;

endpackage

`default_nettype wire

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// ----------------------------------------------------------------------------
// btn_debounce : 2-FF synchroniser, stable-count debouncer, rising press pulse
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module btn_debounce #(
   parameter int unsigned DEB_CYC = 10000
) (
   input  logic Clk,
   input  logic rst_n,
   input  logic btn_i,
   output logic level_o,
   output logic press_o
);

   localparam int unsigned CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

   logic          sync1_q, sync2_q;
   logic          vld1_q, vld2_q;
   logic          armed_q, armed_d;
   logic          lvl_q, lvl_d, lvl_prev_q;
   logic          press_q, press_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // A button found high when the synchroniser first becomes valid stays
   // disarmed until it has been seen low, so a press held through reset is void.
   always_comb begin
      lvl_d = lvl_q;
      cnt_d = '0;
      if (sync2_q != lvl_q) begin
         if (cnt_q == CNT_LAST) begin
            lvl_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      armed_d = armed_q | (vld2_q & ~sync2_q);
      press_d = lvl_q & ~lvl_prev_q & armed_q;
   end

   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         vld1_q     <= 1'b0;
         vld2_q     <= 1'b0;
         armed_q    <= 1'b0;
         lvl_q      <= 1'b0;
         lvl_prev_q <= 1'b0;
         press_q    <= 1'b0;
         cnt_q      <= '0;
      end else begin
         sync1_q    <= btn_i;
         sync2_q    <= sync1_q;
         vld1_q     <= 1'b1;
         vld2_q     <= vld1_q;
         armed_q    <= armed_d;
         lvl_q      <= lvl_d;
         lvl_prev_q <= lvl_q;
         press_q    <= press_d;
         cnt_q      <= cnt_d;
      end
   end

   assign level_o = lvl_q & armed_q;
   assign press_o = press_q;

endmodule

`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
// ----------------------------------------------------------------------------
// stopwatch_ctrl : button debounce, IDLE/RUN/PAUSE FSM, 1 Hz prescaler, lap hold
// Optional lap feature enabled by defining LAP_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int unsigned TICK_DIV = DEF_TICK_DIV,
   parameter int unsigned DEB_CYC  = DEF_DEB_CYC
) (
   input  logic       Clk,
   input  logic       rst_n,
   input  logic       start_stop,
   input  logic       Clear,
   input  logic       lap,
   output logic       sec_tick,
   output logic       clr_pulse,
   output logic       run_en,
   output logic       lap_hold,
   output logic [1:0] state
);

   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

   logic          w_ss_press, w_ss_level_unused;
   logic          w_clr_press, w_clr_level;
   logic [1:0]    state_q, state_d;
   logic [PW-1:0] pre_q, pre_d;
   logic          tick_q, tick_d;
   logic          clrp_q;
   logic          run_q;

   btn_debounce #(.DEB_CYC(DEB_CYC)) u_ss (
      .Clk     (Clk),
      .rst_n   (rst_n),
      .btn_i   (start_stop),
      .level_o (w_ss_level_unused),
      .press_o (w_ss_press)
   );

   btn_debounce #(.DEB_CYC(DEB_CYC)) u_clr (
      .Clk     (Clk),
      .rst_n   (rst_n),
      .btn_i   (Clear),
      .level_o (w_clr_level),
      .press_o (w_clr_press)
   );

   always_comb begin
      state_d = state_q;
      if (w_clr_press) begin
         state_d = ST_IDLE;
      end else if (w_ss_press && !w_clr_level) begin
         case (state_q)
            ST_IDLE:  state_d = ST_RUN;
            ST_RUN:   state_d = ST_PAUSE;
            ST_PAUSE: state_d = ST_RUN;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // Only cycles that stay in RUN advance the count, so the cycle leaving RUN
   // neither ticks nor consumes part of the held fractional second.
   always_comb begin
      pre_d  = pre_q;
      tick_d = 1'b0;
      if (state_d == ST_IDLE) begin
         pre_d = '0;
      end else if (state_q == ST_RUN && state_d == ST_RUN) begin
         if (pre_q == PRE_LAST) begin
            pre_d  = '0;
            tick_d = 1'b1;
         end else begin
            pre_d = pre_q + 1'b1;
         end
      end
   end

   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pre_q   <= '0;
         tick_q  <= 1'b0;
         clrp_q  <= 1'b0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         tick_q  <= tick_d;
         clrp_q  <= w_clr_press;
         run_q   <= (state_d == ST_RUN);
      end
   end

`ifdef LAP_EN
   logic w_lap_press, w_lap_level_unused;
   logic lap_q, lap_d;

   btn_debounce #(.DEB_CYC(DEB_CYC)) u_lap (
      .Clk     (Clk),
      .rst_n   (rst_n),
      .btn_i   (lap),
      .level_o (w_lap_level_unused),
      .press_o (w_lap_press)
   );

   always_comb begin
      lap_d = lap_q;
      if (w_clr_press || state_d == ST_IDLE) begin
         lap_d = 1'b0;
      end else if (w_lap_press) begin
         if (state_q == ST_RUN) begin
            lap_d = ~lap_q;
         end else if (state_q == ST_PAUSE) begin
            lap_d = 1'b0;
         end
      end
   end

   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         lap_q <= 1'b0;
      end else begin
         lap_q <= lap_d;
      end
   end

   assign lap_hold = lap_q;
`else
   logic w_lap_unused;
   assign w_lap_unused = lap;
   assign lap_hold     = 1'b0;
`endif

   assign sec_tick  = tick_q;
   assign clr_pulse = clrp_q;
   assign run_en    = run_q;
   assign state     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_stopwatch_ctrl : event scoreboard plus debounce vector table for stopwatch_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_stopwatch_ctrl;

   localparam int TD  = 10;
   localparam int DC  = 4;
   localparam int LAT = DC + 4;   // pin rise to state/clr_pulse visible

   logic       Clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start_stop = 1'b0;
   logic       Clear = 1'b0;
   logic       lap = 1'b0;
   logic       sec_tick, clr_pulse, run_en, lap_hold;
   logic [1:0] state;

   stopwatch_ctrl #(.TICK_DIV(TD), .DEB_CYC(DC)) dut (
      .Clk        (Clk),
      .rst_n      (rst_n),
      .start_stop (start_stop),
      .Clear      (Clear),
      .lap        (lap),
      .sec_tick   (sec_tick),
      .clr_pulse  (clr_pulse),
      .run_en     (run_en),
      .lap_hold   (lap_hold),
      .state      (state)
   );

   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   // kind: 0 sec_tick, 1 clr_pulse, 2 state change, 3 lap_hold change
   typedef struct { int kind; int val; int at; } ev_t;
   ev_t sbq[$];

   typedef struct { bit ss; bit clr; int w; logic [1:0] st; } vec_t;
   vec_t vt[11];

   int  n_chk = 0;
   int  n_pass = 0;
   bit  sb_en = 1'b0;
   logic [1:0] prev_state = 2'b00;
   logic       prev_lap = 1'b0;

   function automatic void check(string name, int act, int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endfunction

   function automatic void sb_push(int kind, int val, int at);
      ev_t e;
      int  i;
      e.kind = kind; e.val = val; e.at = at;
      i = 0;
      while (i < sbq.size() && (sbq[i].at * 4 + sbq[i].kind) <= (at * 4 + kind)) i++;
      sbq.insert(i, e);
   endfunction

   function automatic void sb_observe(string name, int kind, int val);
      ev_t e;
      if (sbq.size() != 0) e = sbq.pop_front();
      else begin e.kind = -1; e.val = -1; e.at = -1; end
      check({name, " cycle"}, cyc, e.at);
      check({name, " event"}, kind * 4 + val, e.kind * 4 + e.val);
   endfunction

   always @(negedge Clk) begin
      if (sb_en) begin
         if (sec_tick)            sb_observe("sec_tick", 0, 1);
         if (clr_pulse)           sb_observe("clr_pulse", 1, 1);
         if (state != prev_state) sb_observe("state", 2, int'(state));
         if (lap_hold != prev_lap) sb_observe("lap_hold", 3, int'(lap_hold));
         check("run_en vs state", int'(run_en), int'(state == 2'b01));
      end
      prev_state = state;
      prev_lap   = lap_hold;
   end

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge Clk);
   endtask

   task automatic pulse(input bit ss, input bit clr, input bit lp, input int w);
      if (ss)  start_stop = 1'b1;
      if (clr) Clear = 1'b1;
      if (lp)  lap = 1'b1;
      repeat (w) @(negedge Clk);
      if (ss)  start_stop = 1'b0;
      if (clr) Clear = 1'b0;
      if (lp)  lap = 1'b0;
   endtask

   task automatic drain();
      int b;
      b = 0;
      while (sbq.size() != 0 && b < 200) begin @(negedge Clk); b++; end
      repeat (25) @(negedge Clk);
      check("scoreboard drained", sbq.size(), 0);
      sbq.delete();
   endtask

   task automatic check_reset_outputs(string tag);
      check({tag, " sec_tick"},  int'(sec_tick), 0);
      check({tag, " clr_pulse"}, int'(clr_pulse), 0);
      check({tag, " run_en"},    int'(run_en), 0);
      check({tag, " lap_hold"},  int'(lap_hold), 0);
      check({tag, " state"},     int'(state), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, m, r, c, a, b, d;
      vt = '{
         '{1'b1, 1'b0, 2, 2'b00},
         '{1'b1, 1'b0, 3, 2'b00},
         '{1'b1, 1'b0, 4, 2'b01},
         '{1'b1, 1'b0, 3, 2'b01},
         '{1'b1, 1'b0, 5, 2'b10},
         '{1'b0, 1'b1, 3, 2'b10},
         '{1'b1, 1'b0, 6, 2'b01},
         '{1'b0, 1'b1, 4, 2'b00},
         '{1'b1, 1'b1, 6, 2'b00},
         '{1'b1, 1'b0, 6, 2'b01},
         '{1'b1, 1'b1, 6, 2'b00}
      };

      repeat (3) @(negedge Clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      repeat (6) @(negedge Clk);
      sb_en = 1'b1;

      // Start with a long press, pause with 5 counts held, resume, then clear+ss together
      t = cyc;
      sb_push(2, 1, t + LAT);
      sb_push(0, 1, t + LAT + 10);
      sb_push(0, 1, t + LAT + 20);
      sb_push(2, 2, t + LAT + 26);
      m = t + 26;
      r = m + 30;
      sb_push(2, 1, r + LAT);
      sb_push(0, 1, r + LAT + 5);
      sb_push(0, 1, r + LAT + 15);
      sb_push(0, 1, r + LAT + 25);
      c = r + LAT + 20;
      sb_push(1, 1, c + LAT);
      sb_push(2, 0, c + LAT);
      pulse(1'b1, 1'b0, 1'b0, 20);
      wait_until(m); pulse(1'b1, 1'b0, 1'b0, 6);
      wait_until(r); pulse(1'b1, 1'b0, 1'b0, 6);
      wait_until(c); pulse(1'b1, 1'b1, 1'b0, 6);
      drain();

      // Clear held blocks start; after release start works
      a = cyc;
      sb_push(1, 1, a + LAT);
      Clear = 1'b1;
      wait_until(a + 20); pulse(1'b1, 1'b0, 1'b0, 6);
      wait_until(a + 40); Clear = 1'b0;
      wait_until(a + 60);
      b = cyc;
      d = b + 30;
      sb_push(2, 1, b + LAT);
      sb_push(0, 1, b + LAT + 10);
      sb_push(0, 1, b + LAT + 20);
      sb_push(1, 1, d + LAT);
      sb_push(2, 0, d + LAT);
      pulse(1'b1, 1'b0, 1'b0, 6);
      wait_until(d); pulse(1'b0, 1'b1, 1'b0, 6);
      drain();

      // Lap presses while running, then clear
      b = cyc;
      sb_push(2, 1, b + LAT);
      for (int k = 1; k <= 6; k++) sb_push(0, 1, b + LAT + 10 * k);
      sb_push(1, 1, b + 70 + LAT);
      sb_push(2, 0, b + 70 + LAT);
`ifdef LAP_EN
      sb_push(3, 1, b + 10 + LAT);
      sb_push(3, 0, b + 30 + LAT);
      sb_push(3, 1, b + 50 + LAT);
      sb_push(3, 0, b + 70 + LAT);
`endif
      pulse(1'b1, 1'b0, 1'b0, 6);
      wait_until(b + 10); pulse(1'b0, 1'b0, 1'b1, 6);
      wait_until(b + 30); pulse(1'b0, 1'b0, 1'b1, 6);
      wait_until(b + 50); pulse(1'b0, 1'b0, 1'b1, 6);
      wait_until(b + 70); pulse(1'b0, 1'b1, 1'b0, 6);
      drain();

      // Debounce width / transition table
      sb_en = 1'b0;
      for (int i = 0; i < 11; i++) begin
         pulse(vt[i].ss, vt[i].clr, 1'b0, vt[i].w);
         repeat (20) @(negedge Clk);
         check($sformatf("vec%0d state", i), int'(state), int'(vt[i].st));
         check($sformatf("vec%0d run_en", i), int'(run_en), int'(vt[i].st == 2'b01));
      end

      // Reset mid-run with start_stop held through it
      pulse(1'b1, 1'b0, 1'b0, 6);
      repeat (20) @(negedge Clk);
      check("pre-reset state", int'(state), 1);
      start_stop = 1'b1;
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("async reset");
      repeat (2) @(negedge Clk);
      rst_n = 1'b1;
      repeat (25) @(negedge Clk);
      check("held-through-reset state", int'(state), 0);
      start_stop = 1'b0;
      repeat (15) @(negedge Clk);
      pulse(1'b1, 1'b0, 1'b0, 6);
      repeat (20) @(negedge Clk);
      check("re-press after reset state", int'(state), 1);
      check("re-press after reset run_en", int'(run_en), 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
